fir_tap_unpacker: RTL

//  Upstream feeder of the FIR tap-buffering stage. Accepts packed tap words from the memory

---
 rtl/fir_tap_unpacker_pkg.sv | 22 ++
 rtl/fir_tap_unpacker_if.sv | 34 +++
 rtl/fir_tap_unpacker.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_tap_unpacker_pkg
// Description : Shared types and helpers for the FIR tap unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_tap_unpacker_pkg;

    // Load sequencing states of the tap unpacker.
    typedef enum logic [1:0] {
        FIR_UNPACK_IDLE = 2'd0,
        FIR_UNPACK_RUN  = 2'd1,
        FIR_UNPACK_DONE = 2'd2
    } fir_unpack_state_e;

    // Integer ceiling division, used to size the per-load word budget.
    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage : fir_tap_unpacker_pkg
`default_nettype wire

// File: rtl/fir_tap_unpacker_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_tap_unpacker_if
// Description : Valid/ready stream bundle (data, byte strobes, handshake).
//               master drives data/strb/valid, slave drives ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_tap_unpacker_if #(
    parameter int unsigned DATA_WIDTH = 32
);

    localparam int unsigned c_STRB_WIDTH = (DATA_WIDTH + 7) / 8;

    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [c_STRB_WIDTH-1:0] strb;

    modport master (
        output valid,
        output data,
        output strb,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  strb,
        output ready
    );

endinterface : fir_tap_unpacker_if
`default_nettype wire

// File: rtl/fir_tap_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : fir_tap_unpacker
// Description : Accepts packed tap words and emits NB_TAPS taps, one per
//               handshake, lane 0 (LSBs) first. Pulses done_o after the last
//               tap of a load, then idles until the next start_i.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_tap_unpacker
    import fir_tap_unpacker_pkg::*;
#(
    parameter int unsigned MEM_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NB_TAPS    = 8
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    input  wire logic          clear_i,
    input  wire logic          start_i,
    fir_tap_unpacker_if.slave  h_packed,
    fir_tap_unpacker_if.master h_serial,
    output logic               busy_o,
    output logic               done_o
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int unsigned c_TPW      = MEM_WIDTH / DATA_WIDTH;
    localparam int unsigned c_NB_WORDS = ceil_div(NB_TAPS, c_TPW);
    localparam int unsigned c_LANE_W   = (c_TPW > 1) ? $clog2(c_TPW) : 1;
    localparam int unsigned c_TAP_W    = $clog2(NB_TAPS) + 1;
    localparam int unsigned c_WORD_W   = $clog2(c_NB_WORDS + 1);

    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(c_TPW - 1);
    localparam logic [c_TAP_W-1:0]  c_TAP_LAST  = c_TAP_W'(NB_TAPS - 1);
    localparam logic [c_TAP_W-1:0]  c_TAP_MAX   = c_TAP_W'(NB_TAPS);
    localparam logic [c_WORD_W-1:0] c_WORD_MAX  = c_WORD_W'(c_NB_WORDS);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    if ((MEM_WIDTH % DATA_WIDTH) != 0) begin : g_bad_ratio
        $error("fir_tap_unpacker: MEM_WIDTH must be a multiple of DATA_WIDTH");
    end
    if ($bits(h_packed.data) != MEM_WIDTH) begin : g_bad_packed_width
        $error("fir_tap_unpacker: h_packed data width differs from MEM_WIDTH");
    end
    if ($bits(h_serial.data) != DATA_WIDTH) begin : g_bad_serial_width
        $error("fir_tap_unpacker: h_serial data width differs from DATA_WIDTH");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    fir_unpack_state_e       r_state;
    logic [MEM_WIDTH-1:0]    r_word;
    logic                    r_word_valid;
    logic [c_LANE_W-1:0]     r_lane;
    logic [c_TAP_W-1:0]      r_tap_cnt;
    logic [c_WORD_W-1:0]     r_word_cnt;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_run;
    logic                    w_out_hs;
    logic                    w_last_lane_hs;
    logic                    w_last_tap_hs;
    logic                    w_words_left;
    logic                    w_in_ready;
    logic                    w_in_hs;
    logic [DATA_WIDTH-1:0]   w_lanes [c_TPW];
    logic                    w_unused_strb;

    // ------------------------------------------------------------------------
    // Lane slicing: lane g is the g-th DATA_WIDTH field counted from the LSB
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < c_TPW; g++) begin : g_lanes
        assign w_lanes[g] = r_word[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    assign w_run          = (r_state == FIR_UNPACK_RUN);
    assign w_out_hs       = h_serial.valid & h_serial.ready;
    assign w_last_lane_hs = w_out_hs & (r_lane == c_LAST_LANE);
    assign w_last_tap_hs  = w_out_hs & (r_tap_cnt == c_TAP_LAST);
    assign w_words_left   = (r_word_cnt < c_WORD_MAX);

    // A new word may enter when the holding register is empty or is being
    // drained on this very cycle, which keeps taps flowing without a bubble.
    assign w_in_ready = w_run & (r_tap_cnt < c_TAP_MAX) & w_words_left
                      & (~r_word_valid | w_last_lane_hs);
    assign w_in_hs    = h_packed.valid & w_in_ready;

    assign h_packed.ready = w_in_ready;

    assign h_serial.valid = w_run & r_word_valid;
    assign h_serial.data  = w_lanes[r_lane];
    assign h_serial.strb  = '1;

    assign busy_o = r_busy;
    assign done_o = r_done;

    // Byte strobes on the packed side carry no information for tap words.
    assign w_unused_strb = ^h_packed.strb;

    // ------------------------------------------------------------------------
    // Load sequencer: FSM, word holding register and lane/tap/word counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= FIR_UNPACK_IDLE;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_lane       <= '0;
            r_tap_cnt    <= '0;
            r_word_cnt   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (clear_i) begin
            r_state      <= FIR_UNPACK_IDLE;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_lane       <= '0;
            r_tap_cnt    <= '0;
            r_word_cnt   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                FIR_UNPACK_IDLE: begin
                    if (start_i) begin
                        r_state      <= FIR_UNPACK_RUN;
                        r_busy       <= 1'b1;
                        r_word_valid <= 1'b0;
                        r_lane       <= '0;
                        r_tap_cnt    <= '0;
                        r_word_cnt   <= '0;
                    end
                end

                FIR_UNPACK_RUN: begin
                    if (w_in_hs) begin
                        r_word     <= h_packed.data;
                        r_word_cnt <= r_word_cnt + c_WORD_W'(1);
                    end
                    if (w_out_hs) begin
                        r_lane    <= (r_lane == c_LAST_LANE) ? '0 : r_lane + c_LANE_W'(1);
                        r_tap_cnt <= r_tap_cnt + c_TAP_W'(1);
                    end
                    // Final tap ends the load; any unread lanes of a partial
                    // last word are dropped with the holding register.
                    if (w_last_tap_hs) begin
                        r_word_valid <= 1'b0;
                        r_state      <= FIR_UNPACK_DONE;
                        r_done       <= 1'b1;
                    end else if (w_in_hs) begin
                        r_word_valid <= 1'b1;
                    end else if (w_last_lane_hs) begin
                        r_word_valid <= 1'b0;
                    end
                end

                FIR_UNPACK_DONE: begin
                    r_state    <= FIR_UNPACK_IDLE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_lane     <= '0;
                    r_tap_cnt  <= '0;
                    r_word_cnt <= '0;
                end

                default: begin
                    r_state      <= FIR_UNPACK_IDLE;
                    r_word_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Presented tap must not change while the consumer stalls it.
    property p_serial_stable;
        @(posedge clk_i) disable iff (!rst_ni)
            (h_serial.valid && !h_serial.ready && !clear_i) |=> $stable(h_serial.data);
    endproperty
    a_serial_stable: assert property (p_serial_stable)
        else $error("fir_tap_unpacker: h_serial.data changed under backpressure");
`endif

endmodule : fir_tap_unpacker
`default_nettype wire
